// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM states,
// segment bit positions and the hex-to-segment lookup table.
package seven_seg_scan_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_OFF = 8'h00;

    // Entry n is the active-high segment pattern for hex digit n (0..F).
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h71, 8'h79, 8'h5E, 8'h39,   // F E d C
        8'h7C, 8'h77, 8'h6F, 8'h7F,   // b A 9 8
        8'h07, 8'h7D, 8'h6D, 8'h66,   // 7 6 5 4
        8'h4F, 8'h5B, 8'h06, 8'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Bus between the value source and the scan controller: value/control in,
// segment and digit drive plus status pulses out.
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      i_enable;
    logic [4*NUM_DIGITS-1:0]   i_value;
    logic                      i_load;
    logic                      i_lzBlank;
    logic [7:0]                o_segments;
    logic [NUM_DIGITS-1:0]     o_digitEn;
    logic                      o_updateAck;
    logic                      o_frameDone;

    modport master (
        output i_enable, i_value, i_load, i_lzBlank,
        input  o_segments, o_digitEn, o_updateAck, o_frameDone
    );

    modport slave (
        input  i_enable, i_value, i_load, i_lzBlank,
        output o_segments, o_digitEn, o_updateAck, o_frameDone
    );
endinterface

// File: rtl/seven_seg_scan_ctrl_hex_to_seven_seg.sv
// Combinational hex nibble to seven-segment encoder; decimal point is never lit.
module hex_to_seven_seg
    import seven_seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_segments
);
    logic [7:0] w_raw;

    assign w_raw = SEG_TABLE[i_nibble];

    // Copy segments a..g from the table and force the decimal point off.
    always_comb begin
        o_segments              = SEG_OFF;
        o_segments[SEG_G:SEG_A] = w_raw[SEG_G:SEG_A];
        o_segments[SEG_DP]      = 1'b0;
    end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-cathode digits.
// Segment/digit outputs are registered from the next-cycle counter values so
// they line up with the current SlotCnt/DigitIdx. New values are applied only
// in IDLE or on the last cycle of a frame.
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input logic               clk,
    input logic               rst_n,
    seven_seg_scan_ctrl_if.slave bus
);
    localparam int VAL_W  = 4 * NUM_DIGITS;
    localparam int SLOT_W = $clog2(PRESCALE);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    scan_state_t           r_state, w_stateNext;
    logic [SLOT_W-1:0]     r_slotCnt, w_slotNext;
    logic [IDX_W-1:0]      r_digitIdx, w_idxNext;
    logic [VAL_W-1:0]      r_display, r_pending, w_displayNext;
    logic                  r_pendingValid;
    logic                  w_frameDone, w_apply;
    logic [3:0]            w_nibble;
    logic [7:0]            w_segEnc, w_segNext, r_segments;
    logic [NUM_DIGITS-1:0] w_digitEnNext, r_digitEn, w_leadZero;
    logic                  w_lzChain;

    // State register: FSM state plus slot and digit counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_slotCnt  <= '0;
            r_digitIdx <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_slotCnt  <= w_slotNext;
            r_digitIdx <= w_idxNext;
        end
    end

    // Next-state logic: counters run only in SCAN and restart from zero on entry.
    always_comb begin
        w_stateNext = r_state;
        w_slotNext  = '0;
        w_idxNext   = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_enable) w_stateNext = ST_SCAN;
            end
            ST_SCAN: begin
                if (!bus.i_enable) begin
                    w_stateNext = ST_IDLE;
                end else if (r_slotCnt == SLOT_LAST) begin
                    w_slotNext = '0;
                    w_idxNext  = (r_digitIdx == IDX_LAST) ? '0 : r_digitIdx + IDX_W'(1);
                end else begin
                    w_slotNext = r_slotCnt + SLOT_W'(1);
                    w_idxNext  = r_digitIdx;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // Apply decision: a Load on an apply cycle bypasses Pending (latest value wins).
    always_comb begin
        w_frameDone   = (r_state == ST_SCAN) && (r_slotCnt == SLOT_LAST) &&
                        (r_digitIdx == IDX_LAST);
        w_apply       = ((r_state == ST_IDLE) || w_frameDone) &&
                        (r_pendingValid || bus.i_load);
        w_displayNext = r_display;
        if (w_apply) w_displayNext = bus.i_load ? bus.i_value : r_pending;
    end

    // Display and pending registers; loads mid-frame wait in Pending until frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_display      <= '0;
            r_pending      <= '0;
            r_pendingValid <= 1'b0;
        end else begin
            r_display <= w_displayNext;
            if (w_apply) begin
                r_pendingValid <= 1'b0;
            end else if (bus.i_load) begin
                r_pending      <= bus.i_value;
                r_pendingValid <= 1'b1;
            end
        end
    end

    // Leading-zero mask and nibble mux for the digit shown next cycle.
    always_comb begin
        w_nibble   = '0;
        w_leadZero = '0;
        w_lzChain  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_lzChain     = w_lzChain && (w_displayNext[(NUM_DIGITS-1-i)*4 +: 4] == 4'h0);
            w_leadZero[i] = w_lzChain;
            if (w_idxNext == IDX_W'(i)) w_nibble = w_displayNext[(NUM_DIGITS-1-i)*4 +: 4];
        end
    end

    hex_to_seven_seg u_encoder (
        .i_nibble   (w_nibble),
        .o_segments (w_segEnc)
    );

    // Output logic: blank at slot start, otherwise drive the selected digit.
    always_comb begin
        w_digitEnNext = '0;
        w_segNext     = SEG_OFF;
        if ((w_stateNext == ST_SCAN) && !(int'(w_slotNext) < BLANK_CYCLES)) begin
            w_digitEnNext = NUM_DIGITS'(1) << w_idxNext;
            if (!(bus.i_lzBlank && w_leadZero[w_idxNext] && (w_idxNext != IDX_LAST)))
                w_segNext = w_segEnc;
        end
    end

    // Output register so pins change cleanly on the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digitEn  <= '0;
            r_segments <= SEG_OFF;
        end else begin
            r_digitEn  <= w_digitEnNext;
            r_segments <= w_segNext;
        end
    end

    assign bus.o_digitEn   = r_digitEn;
    assign bus.o_segments  = r_segments;
    assign bus.o_frameDone = w_frameDone;
    assign bus.o_updateAck = w_apply & rst_n;
endmodule
